// File: rtl/fifo_stream_pkg.sv
// Shared types and constants for the FIFO read-side stream drain stage.
// Optional build macro: FIFO_STREAM_CKSUM_EN (enables the running XOR checksum).
package fifo_stream_pkg;

    localparam int DEFAULT_DATA_W = 32;
    localparam int DEFAULT_CNT_W  = 16;
    localparam int BUF_DEPTH      = 2;

    typedef logic [DEFAULT_DATA_W-1:0] word_t;
    typedef logic [1:0]                occ_t;

    // Free buffer slots once words already held or in flight are accounted for.
    // A pop in the same cycle frees a slot in time for a read issued now,
    // because that read's data only lands on the following edge.
    function automatic logic [2:0] calc_credit(input occ_t occ,
                                               input logic inflight,
                                               input logic pop);
        logic [2:0] c;
        c = 3'(BUF_DEPTH) - {1'b0, occ} - {2'b00, inflight} + {2'b00, pop};
        return c;
    endfunction

endpackage

// File: rtl/fifo_stream_skid.sv
// Two-entry in-order buffer that absorbs the FIFO read latency.
// The head register drives the stream data directly; a write and a pop in the
// same cycle keep the occupancy unchanged while the head advances.
module fifo_stream_skid
    import fifo_stream_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_valid,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output occ_t              occ
);

    logic [DATA_W-1:0] tail;
    logic [DATA_W-1:0] head_nxt;
    logic [DATA_W-1:0] tail_nxt;
    occ_t              occ_nxt;
    logic              do_pop;
    logic              do_wr;

    // Pops of an empty buffer and writes into a full, non-draining buffer are ignored.
    assign do_pop = pop && (occ != 2'd0);
    assign do_wr  = wr_valid && ((occ != 2'd2) || do_pop);

    // Next head/tail/occupancy from the write and pop requests of this cycle.
    always_comb begin
        head_nxt = head;
        tail_nxt = tail;
        occ_nxt  = occ;
        case ({do_wr, do_pop})
            2'b10: begin
                if (occ == 2'd0) begin
                    head_nxt = wr_data;
                end else begin
                    tail_nxt = wr_data;
                end
                occ_nxt = occ + 2'd1;
            end
            2'b01: begin
                head_nxt = tail;
                occ_nxt  = occ - 2'd1;
            end
            2'b11: begin
                if (occ == 2'd1) begin
                    head_nxt = wr_data;
                end else begin
                    head_nxt = tail;
                    tail_nxt = wr_data;
                end
            end
            default: begin
                head_nxt = head;
            end
        endcase
    end

    // Buffer registers; reset discards any held words.
    always_ff @(posedge clk) begin
        if (rst) begin
            head <= '0;
            tail <= '0;
            occ  <= 2'd0;
        end else begin
            head <= head_nxt;
            tail <= tail_nxt;
            occ  <= occ_nxt;
        end
    end

endmodule

// File: rtl/fifo_stream_out.sv
// Read-side drain stage for a synchronous FIFO with one-cycle read latency.
// Issues FIFO reads while buffer credit exists and presents the words on a
// valid/ready stream with no bubbles under continuous ready.
// Optional build macro: FIFO_STREAM_CKSUM_EN adds a running XOR checksum of
// delivered words on cksum; without it cksum is constant zero.
module fifo_stream_out
    import fifo_stream_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int CNT_W  = DEFAULT_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    output logic              rd_en,
    input  logic [DATA_W-1:0] data_out,
    input  logic              empty,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic [CNT_W-1:0]  word_cnt,
    output logic [DATA_W-1:0] cksum
);

    occ_t       occ;
    logic       inflight;
    logic       pop;
    logic [2:0] credit;

    assign m_valid = (occ != 2'd0);
    assign pop     = m_valid && m_ready;
    assign credit  = calc_credit(occ, inflight, pop);

    // Read issue: never while empty or in reset, and only with a free slot.
    always_comb begin
        rd_en = 1'b0;
        if (en && !empty && !rst && (credit != 3'd0)) begin
            rd_en = 1'b1;
        end
    end

    // A read issued this cycle delivers its word on data_out next cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            inflight <= 1'b0;
        end else begin
            inflight <= rd_en;
        end
    end

    fifo_stream_skid #(
        .DATA_W (DATA_W)
    ) u_skid (
        .clk      (clk),
        .rst      (rst),
        .wr_valid (inflight),
        .wr_data  (data_out),
        .pop      (pop),
        .head     (m_data),
        .occ      (occ)
    );

    // Delivered-word counter, wrapping at its full width.
    always_ff @(posedge clk) begin
        if (rst) begin
            word_cnt <= '0;
        end else if (pop) begin
            word_cnt <= word_cnt + CNT_W'(1);
        end
    end

`ifdef FIFO_STREAM_CKSUM_EN
    logic [DATA_W-1:0] cksum_q;

    // Running XOR of every word accepted by the sink.
    always_ff @(posedge clk) begin
        if (rst) begin
            cksum_q <= '0;
        end else if (pop) begin
            cksum_q <= cksum_q ^ m_data;
        end
    end

    assign cksum = cksum_q;
`else
    assign cksum = '0;
`endif

endmodule
